// File: rtl/aes_cbc_dec_ctrl.sv
// aes_cbc_dec_ctrl: sequencer for an external combinational AES-128 CBC
// decryption core (aes_dec_cbc). It accepts one ciphertext block at a time,
// holds it stable on the core inputs for CORE_LAT cycles, captures the
// plaintext and presents it downstream. The chaining value is advanced to
// the consumed ciphertext block on each capture.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   key                  decryption key, forwarded to core_key
//   iv                   initial vector, sampled when a start is accepted
//   start                begins a new message (honoured only when idle)
//   s_valid/s_ready      ciphertext handshake; s_data block, s_last final flag
//   core_in/core_iv/     drive the external core
//   core_key
//   core_out             plaintext from the external core
//   m_valid/m_ready      plaintext handshake; m_data block, m_last final flag
//   blk_cnt              blocks emitted in the current message
//   busy                 high whenever a message is in progress
module aes_cbc_dec_ctrl #(
    parameter int unsigned CORE_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         start,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic         s_last,
    output logic [127:0] core_in,
    output logic [127:0] core_iv,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_last,
    output logic [15:0]  blk_cnt,
    output logic         busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWait,
        StOutput
    } state_e;

    localparam logic [3:0] LatLast = 4'(CORE_LAT - 1);

    state_e       state;
    logic [127:0] chain;
    logic [127:0] ct_reg;
    logic [127:0] pt_reg;
    logic         last_reg;
    logic [3:0]   wait_cnt;

    // s_ready, m_valid and busy are registered alongside the state so the
    // handshake outputs are glitch-free decodes of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            chain    <= '0;
            ct_reg   <= '0;
            pt_reg   <= '0;
            last_reg <= 1'b0;
            wait_cnt <= '0;
            blk_cnt  <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        chain   <= iv;
                        blk_cnt <= '0;
                        state   <= StAccept;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                StAccept: begin
                    if (s_valid && s_ready) begin
                        ct_reg   <= s_data;
                        last_reg <= s_last;
                        wait_cnt <= '0;
                        state    <= StWait;
                        s_ready  <= 1'b0;
                    end
                end
                StWait: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    // core_in/core_iv have been stable for CORE_LAT cycles here
                    if (wait_cnt == LatLast) begin
                        pt_reg  <= core_out;
                        chain   <= ct_reg;
                        state   <= StOutput;
                        m_valid <= 1'b1;
                    end
                end
                StOutput: begin
                    if (m_ready) begin
                        blk_cnt <= blk_cnt + 16'd1;
                        m_valid <= 1'b0;
                        if (last_reg) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            state   <= StAccept;
                            s_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= StIdle;
                    s_ready <= 1'b0;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign core_in  = ct_reg;
    assign core_iv  = chain;
    assign core_key = key;
    assign m_data   = pt_reg;
    assign m_last   = last_reg;

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Testbench for aes_cbc_dec_ctrl. Three instances are built: index 0 with
// the default CORE_LAT=2 carries the functional tests, indices 1 and 2
// (CORE_LAT=1 and 4) are used for latency measurement. Each instance is
// paired with a stand-in for the external aes_dec_cbc core that knows the
// SP800-38A CBC-AES128 vectors and applies a simple keyed bijection to any
// other block, followed by the CBC xor with core_iv.
module tb_aes_cbc_dec_ctrl;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in   [3];
    logic [127:0] iv_in    [3];
    logic         start    [3];
    logic         s_valid  [3];
    logic         s_ready  [3];
    logic [127:0] s_data   [3];
    logic         s_last   [3];
    logic [127:0] core_in  [3];
    logic [127:0] core_iv  [3];
    logic [127:0] core_key [3];
    logic [127:0] core_out [3];
    logic         m_valid  [3];
    logic         m_ready  [3];
    logic [127:0] m_data   [3];
    logic         m_last   [3];
    logic [15:0]  blk_cnt  [3];
    logic         busy     [3];

    int n_checks = 0;
    int n_fail   = 0;
    int xfers    = 0;
    logic [127:0] last_xfer_data;
    logic         last_xfer_last;

    // Reference model: expected outputs of instance 0 in emission order.
    logic [127:0] exp_data [$];
    logic         exp_last [$];
    logic [15:0]  exp_cnt  [$];
    logic [127:0] chain_m;
    logic [15:0]  idx_m;

    // Block-cipher decryption (ECB) as seen by the stand-in core.
    function automatic logic [127:0] ecb_dec(input logic [127:0] c, input logic [127:0] k);
        if (c == CT1) return PT1 ^ IV0;
        if (c == CT2) return PT2 ^ CT1;
        return {c[63:0], c[127:64]} ^ k;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        aes_cbc_dec_ctrl #(.CORE_LAT(L)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .key      (key_in[g]),
            .iv       (iv_in[g]),
            .start    (start[g]),
            .s_valid  (s_valid[g]),
            .s_ready  (s_ready[g]),
            .s_data   (s_data[g]),
            .s_last   (s_last[g]),
            .core_in  (core_in[g]),
            .core_iv  (core_iv[g]),
            .core_key (core_key[g]),
            .core_out (core_out[g]),
            .m_valid  (m_valid[g]),
            .m_ready  (m_ready[g]),
            .m_data   (m_data[g]),
            .m_last   (m_last[g]),
            .blk_cnt  (blk_cnt[g]),
            .busy     (busy[g])
        );
        assign core_out[g] = ecb_dec(core_in[g], core_key[g]) ^ core_iv[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process for instance 0: every cycle with m_valid high is
    // checked against the head of the model queue.
    always @(negedge clk) begin
        if (rst_n) begin
            check("s_ready_m_valid_exclusive", 128'(s_ready[0] && m_valid[0]), 128'd0);
            if (m_valid[0]) begin
                if (exp_data.size() == 0) begin
                    check("unexpected_output", 128'(m_valid[0]), 128'd0);
                end else begin
                    check("m_data", m_data[0], exp_data[0]);
                    check("m_last", 128'(m_last[0]), 128'(exp_last[0]));
                    check("blk_cnt_at_xfer", 128'(blk_cnt[0]), 128'(exp_cnt[0]));
                    if (m_ready[0]) begin
                        last_xfer_data = m_data[0];
                        last_xfer_last = m_last[0];
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                        void'(exp_cnt.pop_front());
                        xfers++;
                    end
                end
            end
        end
    end

    task automatic start_msg(input int u, input logic [127:0] v);
        iv_in[u] = v;
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
        if (u == 0) begin
            chain_m = v;
            idx_m   = '0;
        end
    endtask

    // Presents one block and returns just after the accepting edge.
    task automatic send_block(input int u, input logic [127:0] ct, input logic last);
        int k = 0;
        s_valid[u] = 1'b1;
        s_data[u]  = ct;
        s_last[u]  = last;
        while (!s_ready[u] && k < 100) begin
            tick();
            k++;
        end
        if (!s_ready[u]) begin
            check("accept_timeout", 128'(s_ready[u]), 128'd1);
        end else begin
            if (u == 0) begin
                exp_data.push_back(ecb_dec(ct, KEY) ^ chain_m);
                exp_last.push_back(last);
                exp_cnt.push_back(idx_m);
                chain_m = ct;
                idx_m++;
            end
            tick();
        end
        s_valid[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int k = 0;
        while (busy[u] && k < 200) begin
            tick();
            k++;
        end
        check("idle_timeout", 128'(busy[u]), 128'd0);
    endtask

    // Single-block message with accept-to-m_valid latency measurement.
    task automatic run_single(input int u);
        int k;
        start_msg(u, IV0);
        send_block(u, CT1, 1'b1);
        k = 1;
        while (!m_valid[u] && k < 60) begin
            tick();
            k++;
        end
        check($sformatf("latency_lat%0d", lat_of(u)), 128'(k), 128'(lat_of(u) + 1));
        check("single_m_data", m_data[u], PT1);
        check("single_m_last", 128'(m_last[u]), 128'd1);
        tick();
        check("single_busy_after", 128'(busy[u]), 128'd0);
        check("single_blk_cnt", 128'(blk_cnt[u]), 128'd1);
    endtask

    initial begin
        logic [127:0] held;
        int           k;
        int           x0;
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            key_in[u]  = KEY;
            iv_in[u]   = IV0;
            start[u]   = 1'b0;
            s_valid[u] = 1'b0;
            s_data[u]  = '0;
            s_last[u]  = 1'b0;
            m_ready[u] = 1'b1;
        end
        tick();
        tick();
        // Reset state
        check("rst_s_ready", 128'(s_ready[0]), 128'd0);
        check("rst_m_valid", 128'(m_valid[0]), 128'd0);
        check("rst_m_last", 128'(m_last[0]), 128'd0);
        check("rst_m_data", m_data[0], 128'd0);
        check("rst_busy", 128'(busy[0]), 128'd0);
        check("rst_blk_cnt", 128'(blk_cnt[0]), 128'd0);
        check("rst_core_iv", core_iv[0], 128'd0);
        check("core_key_pass", core_key[0], KEY);
        rst_n = 1'b1;
        tick();

        // Data offered while idle is not consumed.
        s_valid[0] = 1'b1;
        s_data[0]  = 128'hdead_beef;
        for (int i = 0; i < 3; i++) begin
            check("idle_s_ready", 128'(s_ready[0]), 128'd0);
            tick();
        end
        s_valid[0] = 1'b0;

        // Single block, latency at CORE_LAT=2
        run_single(0);
        check("single_xfer_data", last_xfer_data, 128'h6bc1bee22e409f96e93d7e117393172a);
        check("single_xfer_last", 128'(last_xfer_last), 128'd1);

        // Two-block chaining
        start_msg(0, IV0);
        send_block(0, CT1, 1'b0);
        send_block(0, CT2, 1'b1);
        wait_idle(0);
        check("chain_second_pt", last_xfer_data, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
        check("chain_blk_cnt", 128'(blk_cnt[0]), 128'd2);

        // Start with iv=0 mid-message is ignored.
        start_msg(0, IV0);
        send_block(0, CT1, 1'b0);
        iv_in[0] = '0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        send_block(0, CT2, 1'b1);
        wait_idle(0);
        check("ign_start_pt", last_xfer_data, PT2);
        check("ign_start_blk_cnt", 128'(blk_cnt[0]), 128'd2);

        // Backpressure on the first of two blocks.
        m_ready[0] = 1'b0;
        start_msg(0, 128'h0f0e0d0c0b0a09080706050403020100);
        send_block(0, 128'h0123456789abcdeffedcba9876543210, 1'b0);
        k = 0;
        while (!m_valid[0] && k < 50) begin
            tick();
            k++;
        end
        check("bp_m_valid", 128'(m_valid[0]), 128'd1);
        held = m_data[0];
        for (int i = 0; i < 5; i++) begin
            check("bp_m_data_stable", m_data[0], held);
            check("bp_s_ready_low", 128'(s_ready[0]), 128'd0);
            tick();
        end
        x0 = xfers;
        m_ready[0] = 1'b1;
        tick();
        check("bp_one_xfer", 128'(xfers), 128'(x0 + 1));
        check("bp_m_valid_drop", 128'(m_valid[0]), 128'd0);
        send_block(0, 128'hcafef00d_00112233_44556677_8899aabb, 1'b1);
        wait_idle(0);
        check("bp_blk_cnt", 128'(blk_cnt[0]), 128'd2);

        // Three-block message through the generic core path.
        start_msg(0, 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa);
        send_block(0, 128'h1, 1'b0);
        send_block(0, 128'hffffffff_00000000_ffffffff_00000000, 1'b0);
        send_block(0, 128'h80000000_00000000_00000000_00000001, 1'b1);
        wait_idle(0);
        check("three_blk_cnt", 128'(blk_cnt[0]), 128'd3);

        // Reset while waiting on the core.
        start_msg(0, IV0);
        send_block(0, CT1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("wrst_s_ready", 128'(s_ready[0]), 128'd0);
        check("wrst_m_valid", 128'(m_valid[0]), 128'd0);
        check("wrst_m_last", 128'(m_last[0]), 128'd0);
        check("wrst_m_data", m_data[0], 128'd0);
        check("wrst_busy", 128'(busy[0]), 128'd0);
        check("wrst_blk_cnt", 128'(blk_cnt[0]), 128'd0);
        check("wrst_core_in", core_in[0], 128'd0);
        check("wrst_core_iv", core_iv[0], 128'd0);
        exp_data.delete();
        exp_last.delete();
        exp_cnt.delete();
        #1 rst_n = 1'b1;
        tick();
        s_valid[0] = 1'b1;
        s_data[0]  = CT2;
        for (int i = 0; i < 4; i++) begin
            check("post_rst_idle", 128'({s_ready[0], busy[0]}), 128'd0);
            tick();
        end
        s_valid[0] = 1'b0;
        run_single(0);

        // Latency at CORE_LAT=1 and CORE_LAT=4
        run_single(1);
        run_single(2);

        tick();
        check("queue_drained", 128'(exp_data.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
